// File: rtl/speed_button_ctrl.sv
// ---------------------------------------------------------------------------
// speed_button_ctrl
//
// Debounces a bouncing push-button and steps a speed index once per accepted
// press. The raw button is brought into the clock domain through a two-flop
// synchronizer. A four-state FSM with one shared counter then requires
// DEBOUNCE_CYCLES consecutive stable samples before it accepts a press or a
// release.
//
// Parameters
//   DEBOUNCE_CYCLES : stable samples needed to accept an edge (2..2^24)
//   NUM_SPEEDS      : number of selectable speed levels (2..16)
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   button_raw   in   asynchronous bouncing button, 1 = pressed
//   speedButton  out  debounced button level (PRESSED or DB_RELEASE)
//   press_pulse  out  one-cycle strobe per accepted press
//   speed_level  out  current speed index, 0..NUM_SPEEDS-1
//
// Configuration macro
//   SPEED_WRAP_EN : when defined, a press at the top level wraps to 0.
//                   When undefined (the default build), the level saturates.
// ---------------------------------------------------------------------------
module speed_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SPEEDS      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_raw,
    output logic       speedButton,
    output logic       press_pulse,
    output logic [3:0] speed_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       LEVEL_MAX = 4'(NUM_SPEEDS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic             sync_1;
    logic             btn_s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             accept;
    logic [3:0]       level_inc;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1 <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_1 <= button_raw;
            btn_s  <= sync_1;
        end
    end

    // FSM state and shared debounce counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= CNT_ZERO;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic. The counter is cleared on every state change, so it
    // always reads 0 in IDLE and PRESSED.
    always_comb begin
        next_state = state;
        next_count = count;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    next_state = DB_PRESS;
                    next_count = CNT_ZERO;
                end else begin
                    next_state = IDLE;
                    next_count = CNT_ZERO;
                end
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    next_state = IDLE;
                    next_count = CNT_ZERO;
                end else if (count == CNT_MAX) begin
                    next_state = PRESSED;
                    next_count = CNT_ZERO;
                    accept     = 1'b1;
                end else begin
                    next_state = DB_PRESS;
                    next_count = count + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    next_state = DB_RELEASE;
                    next_count = CNT_ZERO;
                end else begin
                    next_state = PRESSED;
                    next_count = CNT_ZERO;
                end
            end
            DB_RELEASE: begin
                // A bounce back to 1 returns to PRESSED without a new press.
                if (btn_s) begin
                    next_state = PRESSED;
                    next_count = CNT_ZERO;
                end else if (count == CNT_MAX) begin
                    next_state = IDLE;
                    next_count = CNT_ZERO;
                end else begin
                    next_state = DB_RELEASE;
                    next_count = count + CNT_ONE;
                end
            end
            default: begin
                next_state = IDLE;
                next_count = CNT_ZERO;
            end
        endcase
    end

    // Registered outputs, computed from the next state so that they line up
    // with the first cycle spent in the new state.
    always_ff @(posedge clock) begin
        if (reset) begin
            press_pulse <= 1'b0;
            speedButton <= 1'b0;
        end else begin
            press_pulse <= accept;
            speedButton <= (next_state == PRESSED) || (next_state == DB_RELEASE);
        end
    end

    // Next speed index at the top level: wrap or saturate, chosen at build time.
    always_comb begin
        level_inc = speed_level;
        if (speed_level < LEVEL_MAX) begin
            level_inc = speed_level + 4'd1;
        end else begin
`ifdef SPEED_WRAP_EN
            level_inc = 4'd0;
`else
            level_inc = LEVEL_MAX;
`endif
        end
    end

    // Speed index register. It advances while press_pulse is high, so the
    // new value appears one cycle after the pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            speed_level <= 4'd0;
        end else if (press_pulse) begin
            speed_level <= level_inc;
        end else begin
            speed_level <= speed_level;
        end
    end

endmodule

// File: tb/tb_speed_button_ctrl.sv
// ---------------------------------------------------------------------------
// tb_speed_button_ctrl
//
// Directed self-checking bench for speed_button_ctrl with DEBOUNCE_CYCLES=4
// and NUM_SPEEDS=4. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_speed_button_ctrl;

    logic       clock;
    logic       reset;
    logic       button_raw;
    logic       speedButton;
    logic       press_pulse;
    logic [3:0] speed_level;

    int n_checks;
    int n_fail;

    speed_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .NUM_SPEEDS     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button_raw (button_raw),
        .speedButton(speedButton),
        .press_pulse(press_pulse),
        .speed_level(speed_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        button_raw = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulse: got %b expected 0", press_pulse);
        end
        n_checks++;
        if (speedButton !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_speedButton: got %b expected 0", speedButton);
        end
        n_checks++;
        if (speed_level !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_level: got %0d expected 0", speed_level);
        end
        button_raw = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_bounce();
        int pulses;
        int sb_high;
        pulses  = 0;
        sb_high = 0;
        for (int r = 0; r < 5; r++) begin
            button_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (press_pulse === 1'b1) pulses++;
                if (speedButton !== 1'b0) sb_high++;
            end
            button_raw = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (press_pulse === 1'b1) pulses++;
                if (speedButton !== 1'b0) sb_high++;
            end
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (sb_high != 0) begin
            n_fail++;
            $display("FAIL bounce_speedButton: high for %0d cycles, expected 0", sb_high);
        end
        n_checks++;
        if (speed_level !== 4'd0) begin
            n_fail++;
            $display("FAIL bounce_level: got %0d expected 0", speed_level);
        end
    endtask

    task automatic test_clean_press();
        int pulses;
        int first;
        pulses     = 0;
        first      = -1;
        button_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == 7) begin
                n_checks++;
                if (speed_level !== 4'd0) begin
                    n_fail++;
                    $display("FAIL clean_level_during_pulse: got %0d expected 0", speed_level);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (speed_level !== 4'd1) begin
                    n_fail++;
                    $display("FAIL clean_level_after_pulse: got %0d expected 1", speed_level);
                end
            end
        end
        n_checks++;
        if (first != 7) begin
            n_fail++;
            $display("FAIL clean_latency: pulse at tick %0d expected 7", first);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL clean_pulse_count: got %0d expected 1", pulses);
        end
        n_checks++;
        if (speedButton !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_speedButton: got %b expected 1", speedButton);
        end
        button_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (speedButton !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_release: speedButton got %b expected 0", speedButton);
        end
        n_checks++;
        if (speed_level !== 4'd1) begin
            n_fail++;
            $display("FAIL clean_level_hold: got %0d expected 1", speed_level);
        end
    endtask

    task automatic test_release_bounce();
        int pulses;
        int sb_low;
        pulses     = 0;
        sb_low     = 0;
        button_raw = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (speed_level !== 4'd2) begin
            n_fail++;
            $display("FAIL relbounce_level_before: got %0d expected 2", speed_level);
        end
        button_raw = 1'b0;
        tick();
        tick();
        button_raw = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (speedButton !== 1'b1) sb_low++;
            if (press_pulse === 1'b1) pulses++;
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (speedButton !== 1'b1) sb_low++;
            if (press_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (sb_low != 0) begin
            n_fail++;
            $display("FAIL relbounce_speedButton: low for %0d cycles expected 0", sb_low);
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL relbounce_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (speed_level !== 4'd2) begin
            n_fail++;
            $display("FAIL relbounce_level: got %0d expected 2", speed_level);
        end
        button_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_four_presses();
        logic [3:0] exp_level [4];
        int pulses;
        exp_level[0] = 4'd1;
        exp_level[1] = 4'd2;
        exp_level[2] = 4'd3;
`ifdef SPEED_WRAP_EN
        exp_level[3] = 4'd0;
`else
        exp_level[3] = 4'd3;
`endif
        pulses = 0;
        for (int p = 0; p < 4; p++) begin
            button_raw = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (press_pulse === 1'b1) pulses++;
            end
            button_raw = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (press_pulse === 1'b1) pulses++;
            end
            n_checks++;
            if (speed_level !== exp_level[p]) begin
                n_fail++;
                $display("FAIL four_press_level[%0d]: got %0d expected %0d",
                         p, speed_level, exp_level[p]);
            end
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL four_press_pulses: got %0d expected 4", pulses);
        end
    endtask

    // hold = ticks with raw high before reset; 6 puts the FSM one edge away
    // from entering PRESSED.
    task automatic test_reset_mid_debounce(input int hold);
        int first;
        int pulses;
        first      = -1;
        pulses     = 0;
        button_raw = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid%0d_pulse: got %b expected 0", hold, press_pulse);
        end
        n_checks++;
        if (speedButton !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid%0d_speedButton: got %b expected 0", hold, speedButton);
        end
        n_checks++;
        if (speed_level !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid%0d_level: got %0d expected 0", hold, speed_level);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_pulse === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (first != 7) begin
            n_fail++;
            $display("FAIL rstmid%0d_latency: pulse at edge %0d expected 7", hold, first);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL rstmid%0d_pulses: got %0d expected 1", hold, pulses);
        end
        n_checks++;
        if (speed_level !== 4'd1) begin
            n_fail++;
            $display("FAIL rstmid%0d_level_after: got %0d expected 1", hold, speed_level);
        end
        button_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        button_raw = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_release_bounce();
        // Restart from level 0 so the four-press sequence is 1,2,3,wrap/sat.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        test_four_presses();
        test_reset_mid_debounce(4);
        test_reset_mid_debounce(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/speed_button_ctrl.md
SPEED_BUTTON_CTRL -- requirements
Module: speed_button_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-sample count required to accept a button edge (range 2..2^24).
REQ-002 The block SHALL have parameter NUM_SPEEDS, default 4, number of selectable speed levels (range 2..16).
REQ-003 The block SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port button_raw  input  1  asynchronous, bouncing push-button (1 = pressed).
REQ-006 The block SHALL have port speedButton  output  1  debounced button level; drives the clock divider's speedButton input.
REQ-007 The block SHALL have port press_pulse  output  1  single-cycle strobe per accepted press.
REQ-008 The block SHALL have port speed_level  output  4  current speed index, 0..NUM_SPEEDS-1.

Function
REQ-009 button_raw SHALL pass through a 2-flop synchronizer; btn_s (second flop) is the only internal view of the button.
REQ-010 The FSM SHALL have states IDLE, DB_PRESS, PRESSED, DB_RELEASE, with a shared debounce counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 IDLE: btn_s=1 -> DB_PRESS, counter cleared to 0; otherwise stay.
REQ-012 DB_PRESS: btn_s=0 -> IDLE, counter cleared; btn_s=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-013 PRESSED: btn_s=0 -> DB_RELEASE, counter cleared; otherwise stay.
REQ-014 DB_RELEASE: btn_s=1 -> PRESSED, counter cleared; btn_s=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-015 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL hold 0 in IDLE and PRESSED.
REQ-016 press_pulse SHALL be registered, high for exactly one cycle, coincident with the first cycle in PRESSED entered from DB_PRESS; DB_RELEASE->PRESSED SHALL NOT pulse.
REQ-017 Latency: with button_raw held at 1 from a sampling edge E in IDLE, press_pulse SHALL be high in the cycle after edge E+DEBOUNCE_CYCLES+2.
REQ-018 speedButton SHALL be 1 exactly while state is PRESSED or DB_RELEASE, registered.
REQ-019 speed_level SHALL update in the same cycle press_pulse is high, with a new value visible the cycle after; otherwise it holds.
REQ-020 Increment rule: speed_level < NUM_SPEEDS-1 -> speed_level+1; at NUM_SPEEDS-1 see REQ-026; upper unused bits of speed_level SHALL read 0.
REQ-021 A bounce shorter than DEBOUNCE_CYCLES stable samples SHALL produce no pulse, no level change, and no speedButton toggle.

Reset
REQ-022 When reset=1 at a clock edge, the FSM SHALL go to IDLE, and the counter, both synchronizer flops, press_pulse, speedButton and speed_level SHALL all go to 0.
REQ-023 Reset SHALL override every other event in the same cycle, including a pending PRESSED transition.
REQ-024 A button held through reset deassertion SHALL be re-debounced in full; the first pulse obeys REQ-017 counted from the first post-reset edge.

Configuration
REQ-025 Macro SPEED_WRAP_EN SHALL select the wrap behaviour at the top level.
REQ-026 With SPEED_WRAP_EN defined, a press at NUM_SPEEDS-1 SHALL wrap speed_level to 0; undefined, speed_level SHALL saturate at NUM_SPEEDS-1, and press_pulse still fires.

Verification (DEBOUNCE_CYCLES=4, NUM_SPEEDS=4)
REQ-027 Clean press: raw 0->1 held 20 cycles -> press_pulse is one cycle high after edge E+6, speed_level 0->1, speedButton=1.
REQ-028 Bounce: raw high for 3 cycles then low, repeated 5 times -> press_pulse stays 0, speed_level stays 0, speedButton stays 0.
REQ-029 Four clean presses -> speed_level steps 1,2,3 then 0 (SPEED_WRAP_EN) or 1,2,3,3 (not defined); exactly 4 pulses in both builds.
REQ-030 Release bounce: while PRESSED, raw low 2 cycles then high -> returns to PRESSED, speedButton stays 1, no second pulse.
REQ-031 Reset mid-debounce: reset asserted 1 cycle while in DB_PRESS with raw held 1 -> all outputs 0 next cycle; pulse arrives 7 edges after reset deasserts.
